slow_domain_bridge: RTL
=======================

# slow_domain_bridge

Downstream consumer of the clock generator's divided clock. Runs entirely on `original_clock`. Buffers a fast-rate valid/ready stream in a small FIFO and releases one word per rising edge of the `clock_slower` level. The released word is held stable for a full slow period. Slow-rate logic samples `slow_data`/`slow_valid` on `slow_tick`, without a second clock domain.

## Interface
- `DATA_W`, 16: payload width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of underrun counter.

Ports:
- `original_clock` in 1: sole clock, all logic on posedge.
- `reset_in` in 1: synchronous, active-high reset.
- `clock_slower` in 1: divided clock level from clock generator, registered on `original_clock`; treated as data.
- `in_valid` in 1: upstream word present.
- `in_ready` out 1: FIFO can accept; = ~full.
- `in_data` in DATA_W: upstream payload.
- `slow_tick` out 1: one-cycle pulse, registered, marks a slow-period boundary.
- `slow_valid` out 1: `slow_data` holds a fresh word for this slow period.
- `slow_data` out DATA_W: word released at last tick; held between ticks.
- `underrun_cnt` out CNT_W: saturating count of ticks with empty FIFO.

## Operation
- Edge detect:
  - `prev_q` registers `clock_slower` every cycle.
  - `rise = clock_slower & ~prev_q`.
  - During reset `prev_q <= clock_slower`, so no spurious tick at reset release even if `clock_slower` is high.
- Push: `in_valid & in_ready` at a clock edge writes `in_data` at the write pointer.
- Pop: at an edge where `rise` is 1:
  - FIFO non-empty: `slow_data <=` head, `slow_valid <= 1`, read pointer advances.
  - FIFO empty: `slow_valid <= 0`, `slow_data` keeps its old value, `underrun_cnt` increments, saturating at 2^CNT_W−1.
  - Either way `slow_tick <= 1`.
- At every other edge: `slow_tick <= 0`; `slow_valid`/`slow_data` unchanged.
- Empty/full are judged on registered occupancy before the edge. No bypass: a word pushed on a tick edge with the FIFO empty is not popped on that edge.
- Push and pop on the same edge, non-empty and non-full: both happen, occupancy unchanged.
- When full, `in_ready = 0`; a pop on that edge does not reopen `in_ready` until the next cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Occupancy is `$clog2(DEPTH)+1` bits.
- Reset values:
  - `slow_tick = 0`, `slow_valid = 0`, `slow_data = 0`, `underrun_cnt = 0`.
  - FIFO empty, so `in_ready = 1` the cycle after reset.
- Reset mid-operation flushes all buffered words.

## Timing
- Input accept at edge E → word eligible for pop at the first rising edge E' > E with `rise` = 1.
- `clock_slower` goes 0→1 at edge T, i.e. its register output changes there. `rise` is high during cycle T..T+1. The pop, `slow_data` update and `slow_tick` all appear after edge T+1.
- Latency from the clock-generator register toggle to `slow_tick` is one `original_clock` cycle.
- `slow_tick` period equals the `clock_slower` period: 2·RATIO cycles, i.e. 10 at RATIO = 5.
- `in_ready` is combinational from occupancy only; there is no path from `in_valid`.

## Structure
- No shared-package typedefs needed. Pointer and occupancy widths are local parameters derived from `DEPTH`.
- One sub-module, `bridge_fifo`: a synchronous single-clock FIFO with push/pop/full/empty and the same reset.
- The top level holds the edge detector, output registers and underrun counter.

## Test plan
- Reset hold:
  - Assert `reset_in` 3 cycles with `clock_slower = 1`, then release.
  - Required: no `slow_tick` until the next 0→1 of `clock_slower`; all outputs 0; `in_ready = 1`.
- Basic flow, RATIO = 5 generator driving `clock_slower`:
  - Push 0x1111, 0x2222, 0x3333 back-to-back.
  - Required: three consecutive ticks, 10 cycles apart, present them in order with `slow_valid = 1`.
  - Fourth tick: `slow_valid = 0`, `slow_data` stays 0x3333, `underrun_cnt = 1`.
- Full:
  - Hold `in_valid` with incrementing data 0..7, DEPTH = 4, no ticks.
  - Required: `in_ready` drops after 4 accepts, words 4..7 stall; after one tick exactly one more word is accepted.
- Same-edge push/pop:
  - FIFO has 2 entries; push 0xAAAA on the tick edge.
  - Required: occupancy stays 2; output order is preserved.
- Push into empty on tick edge:
  - Push 0xBEEF exactly on a `rise` edge.
  - Required: that tick gives `slow_valid = 0`; the next tick gives 0xBEEF.
- Saturation and mid-run reset:
  - With CNT_W = 2, run 5 empty ticks. Required: `underrun_cnt` saturates at 3.
  - Then reset with 3 words buffered. Required: the counter clears and the FIFO is empty, with no stale word emitted.

Source files
------------

// File: rtl/slow_domain_bridge_pkg.sv
// Shared defaults for the slow-domain bridge: payload, buffer and counter sizing.
// Pointer and occupancy widths are derived locally from DEPTH in each module.
package slow_domain_bridge_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_CNT_W  = 8;

endpackage : slow_domain_bridge_pkg

// File: rtl/bridge_fifo.sv
// Single-clock synchronous FIFO with push/pop and registered occupancy.
// Full/empty come from occupancy only; requests are ignored when they cannot be honoured.
module bridge_fifo
   import slow_domain_bridge_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              original_clock,
   input  logic              reset_in,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge original_clock) begin
      if (reset_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; emptiness is tracked by count, so stale words are never visible.
   always_ff @(posedge original_clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule : bridge_fifo

// File: rtl/slow_domain_bridge.sv
// Buffers a fast valid/ready stream and releases one word per rising edge of the
// divided clock level, holding it for a full slow period; all logic on original_clock.
module slow_domain_bridge
   import slow_domain_bridge_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              original_clock,
   input  logic              reset_in,
   input  logic              clock_slower,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              slow_tick,
   output logic              slow_valid,
   output logic [DATA_W-1:0] slow_data,
   output logic [CNT_W-1:0]  underrun_cnt
);

   logic              prev_q;
   logic              rise;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] head;

   assign rise     = clock_slower & ~prev_q;
   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;
   assign pop      = rise & ~fifo_empty;

   // Reset also loads the live level, so a high clock_slower at release is not a rise.
   always_ff @(posedge original_clock) begin
      prev_q <= clock_slower;
   end

   bridge_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .original_clock (original_clock),
      .reset_in       (reset_in),
      .push           (push),
      .pop            (pop),
      .wr_data        (in_data),
      .rd_data        (head),
      .full           (fifo_full),
      .empty          (fifo_empty)
   );

   always_ff @(posedge original_clock) begin
      if (reset_in) begin
         slow_tick    <= 1'b0;
         slow_valid   <= 1'b0;
         slow_data    <= '0;
         underrun_cnt <= '0;
      end else if (rise) begin
         slow_tick <= 1'b1;
         if (!fifo_empty) begin
            slow_data  <= head;
            slow_valid <= 1'b1;
         end else begin
            // Underrun: keep the last word, flag it stale, count without wrapping.
            slow_valid <= 1'b0;
            if (underrun_cnt != {CNT_W{1'b1}}) underrun_cnt <= underrun_cnt + 1'b1;
         end
      end else begin
         slow_tick <= 1'b0;
      end
   end

endmodule : slow_domain_bridge
